bfm_apbslave: RTL and testbench



---
 rtl/bfm_apbslave_pkg.sv | 31 +++
 rtl/bfm_apbslave_ram.sv | 41 ++++
 rtl/bfm_apbslave.sv | 141 ++++++++++++++
 tb/tb_bfm_apbslave.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfm_apbslave_pkg.sv
// Shared definitions for the APB3 completer BFM: FSM encoding, bus widths,
// wait-counter width and the address-error decode helper.
package bfm_apbslave_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // An access is rejected when its word index lies beyond the implemented
  // storage, or when alignment checking is on and the byte offset is nonzero.
  function automatic logic addr_err(input logic [31:0] idx,
                                    input logic [1:0]  lo,
                                    input int          depth,
                                    input bit          chk_lo);
    logic bad_idx;
    logic bad_lo;
    bad_idx = (idx >= 32'(depth));
    if (chk_lo) begin
      bad_lo = (lo != 2'b00);
    end else begin
      bad_lo = 1'b0;
    end
    return bad_idx | bad_lo;
  endfunction

endpackage

// File: rtl/bfm_apbslave_ram.sv
// Word storage behind the APB completer: DEPTH x 32 bits, cleared by reset,
// one synchronous write port and one combinational read port.
module bfm_apbslave_ram
  import bfm_apbslave_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [APB_DW-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [APB_DW-1:0] rdata_o
);

  logic [APB_DW-1:0] mem_q [DEPTH];

  // Storage array with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port; indices past the implemented depth read as zero.
  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < 32'(DEPTH)) begin
      rdata_o = mem_q[raddr_i];
    end else begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/bfm_apbslave.sv
// APB3 completer bus-functional model: latches the setup phase, inserts
// WAIT_STATES wait cycles, answers from a word memory and flags protocol misuse.
module bfm_apbslave
  import bfm_apbslave_pkg::*;
#(
  parameter int AWIDTH       = 8,
  parameter int DEPTH        = 256,
  parameter int WAIT_STATES  = 0,
  parameter int ERR_MISALIGN = 1
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PWRITE,
  input  logic              PENABLE,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              PROT_ERR
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  apb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AWIDTH+1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [APB_DW-1:0]   wdata_q, wdata_d;
  logic                prot_err_q, prot_err_d;

  logic                done_s;
  logic                err_s;
  logic                ram_we_s;
  logic [APB_DW-1:0]   ram_rdata_s;

  // State, counter and latched transfer registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      prot_err_q <= prot_err_d;
    end
  end

  // Next-state logic; a repeated setup inside ACCESS restarts the transfer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    prot_err_d = prot_err_q;
    done_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR[AWIDTH+1:0];
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = WAIT_LOAD;
          state_d = ST_ACCESS;
        end else if (PSEL && PENABLE) begin
          prot_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (!PENABLE) begin
          prot_err_d = 1'b1;
          addr_d     = PADDR[AWIDTH+1:0];
          write_d    = PWRITE;
          wdata_d    = PWDATA;
          cnt_d      = WAIT_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign err_s    = addr_err(32'(addr_q[AWIDTH+1:2]), addr_q[1:0], DEPTH,
                             ERR_MISALIGN != 0);
  assign ram_we_s = done_s & write_q & ~err_s;

  // Response outputs are nonzero only in the completing cycle.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (done_s) begin
      PREADY = 1'b1;
      if (err_s) begin
        PSLVERR = 1'b1;
      end else if (!write_q) begin
        PRDATA = ram_rdata_s;
      end else begin
        PRDATA = '0;
      end
    end else begin
      PREADY = 1'b0;
    end
  end

  assign PROT_ERR = prot_err_q;

  bfm_apbslave_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk_i   (PCLK),
    .rst_ni  (PRESETN),
    .we_i    (ram_we_s),
    .waddr_i (addr_q[RAM_AW+1:2]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[RAM_AW+1:2]),
    .rdata_o (ram_rdata_s)
  );

endmodule

// File: tb/tb_bfm_apbslave.sv
// Bench for bfm_apbslave: a zero-wait and a three-wait instance (both DEPTH=16)
// on a shared bus, checked against a word-array reference model.
module tb_bfm_apbslave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1, prot0, prot1;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mem_m [2][16];

  always #5 clk = ~clk;

  bfm_apbslave #(.AWIDTH(8), .DEPTH(16), .WAIT_STATES(0), .ERR_MISALIGN(1)) dut0 (
    .PCLK(clk), .PRESETN(rst_n), .PSEL(psel0), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .PROT_ERR(prot0));

  bfm_apbslave #(.AWIDTH(8), .DEPTH(16), .WAIT_STATES(3), .ERR_MISALIGN(1)) dut1 (
    .PCLK(clk), .PRESETN(rst_n), .PSEL(psel1), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .PROT_ERR(prot1));

  function automatic logic rdy(input int d);
    return (d != 0) ? pready1 : pready0;
  endfunction
  function automatic logic [31:0] prd(input int d);
    return (d != 0) ? prdata1 : prdata0;
  endfunction
  function automatic logic serr(input int d);
    return (d != 0) ? pslverr1 : pslverr0;
  endfunction

  // Reference model: an access is an error iff word index >= 16 or misaligned.
  function automatic bit m_err(input logic [31:0] a);
    return (a[9:2] >= 8'd16) || (a[1:0] != 2'b00);
  endfunction

  task automatic m_apply(input int d, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, output logic [31:0] e_rd, output logic e_err);
    e_err = m_err(a);
    e_rd  = 32'h0;
    if (!e_err && w) mem_m[d][a[5:2]] = wd;
    else if (!e_err) e_rd = mem_m[d][a[5:2]];
  endtask

  function automatic int m_acc(input int d);
    return (d != 0) ? 4 : 1;
  endfunction

  // Count access cycles until PREADY, bounded; starts and ends at posedge+1.
  task automatic wait_done(input int d, input bit scramble, output logic [31:0] rd,
                           output logic err, output int acc, output bit early);
    bit done = 1'b0;
    acc = 0; rd = 32'h0; err = 1'b0; early = 1'b0;
    while (!done && acc < 300) begin
      @(negedge clk);
      acc++;
      if (rdy(d)) begin
        rd = prd(d); err = serr(d); done = 1'b1;
      end else if (prd(d) != 32'h0 || serr(d)) begin
        early = 1'b1;
      end
      @(posedge clk); #1;
      if (scramble && !done) begin
        paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input bit keep, input bit scramble, output logic [31:0] rd,
                      output logic err, output int acc, output bit early);
    bit early_setup;
    psel0 = (d == 0); psel1 = (d != 0);
    paddr = a; pwrite = w; pwdata = wd; penable = 1'b0;
    @(negedge clk);
    early_setup = rdy(d) || (prd(d) != 32'h0) || serr(d);
    @(posedge clk); #1;
    penable = 1'b1;
    if (scramble) begin
      paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom_range(0, 1));
    end
    wait_done(d, scramble, rd, err, acc, early);
    early = early | early_setup;
    if (!keep) begin
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mem_m[d][i] = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({pready0, pslverr0, prot0, pready1, pslverr1, prot1} !== 6'b0) begin
      n_mis++; $display("FAIL reset_flags: got %b exp 000000", {pready0, pslverr0, prot0, pready1, pslverr1, prot1}); end
    n_cmp++; if ({prdata0, prdata1} !== 64'h0) begin
      n_mis++; $display("FAIL reset_prdata: got %h exp 0", {prdata0, prdata1}); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd, erd; logic err, eerr; int acc; bit early;
    xfer(0, 32'h10, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, rd, err, acc, early);
    m_apply(0, 32'h10, 1'b1, 32'hDEADBEEF, erd, eerr);
    n_cmp++; if (acc !== 1) begin n_mis++; $display("FAIL zw_write_cycles: got %0d exp 1", acc); end
    n_cmp++; if (err !== eerr) begin n_mis++; $display("FAIL zw_write_err: got %b exp %b", err, eerr); end
    xfer(0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, rd, err, acc, early);
    m_apply(0, 32'h10, 1'b0, 32'h0, erd, eerr);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_mis++; $display("FAIL zw_read_data: got %h exp deadbeef", rd); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL zw_read_err: got %b exp 0", err); end
    n_cmp++; if (acc !== 1) begin n_mis++; $display("FAIL zw_read_cycles: got %0d exp 1", acc); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, erd; logic err, eerr; int acc; bit early;
    xfer(1, 32'h04, 1'b0, 32'h0, 1'b0, 1'b1, rd, err, acc, early);
    m_apply(1, 32'h04, 1'b0, 32'h0, erd, eerr);
    n_cmp++; if (acc !== 4) begin n_mis++; $display("FAIL ws_read_cycles: got %0d exp 4", acc); end
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL ws_read_data: got %h exp 0", rd); end
    n_cmp++; if (early !== 1'b0) begin n_mis++; $display("FAIL ws_early_resp: got %b exp 0", early); end
    xfer(1, 32'h04, 1'b1, 32'h0BADF00D, 1'b0, 1'b1, rd, err, acc, early);
    m_apply(1, 32'h04, 1'b1, 32'h0BADF00D, erd, eerr);
    xfer(1, 32'h04, 1'b0, 32'h0, 1'b0, 1'b1, rd, err, acc, early);
    m_apply(1, 32'h04, 1'b0, 32'h0, erd, eerr);
    n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL ws_readback: got %h exp %h", rd, erd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic err, eerr; int acc; bit early;
    logic [31:0] ta [5] = '{32'h40, 32'h02, 32'h3C, 32'h00, 32'h40};
    logic        tw [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      xfer(0, ta[i], tw[i], 32'hC0DE0000 | i, 1'b0, 1'b0, rd, err, acc, early);
      m_apply(0, ta[i], tw[i], 32'hC0DE0000 | i, erd, eerr);
      n_cmp++; if (err !== eerr) begin n_mis++; $display("FAIL err_pslverr[%0d]: got %b exp %b", i, err, eerr); end
      n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL err_prdata[%0d]: got %h exp %h", i, rd, erd); end
      n_cmp++; if (acc !== 1) begin n_mis++; $display("FAIL err_cycles[%0d]: got %0d exp 1", i, acc); end
    end
    xfer(0, 32'h3C, 1'b0, 32'h0, 1'b0, 1'b0, rd, err, acc, early);
    m_apply(0, 32'h3C, 1'b0, 32'h0, erd, eerr);
    n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL err_last_word: got %h exp %h", rd, erd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; logic err, eerr; int acc; bit early;
    for (int i = 0; i < 6; i++) begin
      xfer(0, 32'(4 * (i % 3)), (i < 3), 32'(i % 3 + 1), (i != 5), 1'b0, rd, err, acc, early);
      m_apply(0, 32'(4 * (i % 3)), (i < 3), 32'(i % 3 + 1), erd, eerr);
      n_cmp++; if (acc !== 1) begin n_mis++; $display("FAIL b2b_cycles[%0d]: got %0d exp 1", i, acc); end
      if (i >= 3) begin
        n_cmp++; if (rd !== 32'(i - 2)) begin n_mis++; $display("FAIL b2b_read[%0d]: got %h exp %h", i, rd, 32'(i - 2)); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic err, eerr, w; int acc, d; bit early, keep;
    for (int k = 0; k < 80; k++) begin
      d  = int'($urandom_range(0, 1));
      a  = $urandom;
      a[9:2] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      keep = (k != 79) && ($urandom_range(0, 1) == 1);
      xfer(d, a, w, wd, keep, 1'b1, rd, err, acc, early);
      m_apply(d, a, w, wd, erd, eerr);
      n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL rnd_data[%0d] d%0d a=%h: got %h exp %h", k, d, a, rd, erd); end
      n_cmp++; if (err !== eerr) begin n_mis++; $display("FAIL rnd_err[%0d] d%0d a=%h: got %b exp %b", k, d, a, err, eerr); end
      n_cmp++; if (acc !== m_acc(d)) begin n_mis++; $display("FAIL rnd_cycles[%0d]: got %0d exp %0d", k, acc, m_acc(d)); end
      n_cmp++; if (early !== 1'b0) begin n_mis++; $display("FAIL rnd_early[%0d]: got %b exp 0", k, early); end
    end
  endtask

  task automatic test_protocol();
    logic [31:0] rd, erd; logic err, eerr; int acc; bit early;
    // Access phase with no setup on dut0.
    psel0 = 1'b1; psel1 = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h5555AAAA;
    @(negedge clk);
    n_cmp++; if (pready0 !== 1'b0) begin n_mis++; $display("FAIL prot_noready: got %b exp 0", pready0); end
    @(posedge clk); #1;
    psel0 = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_cmp++; if (prot0 !== 1'b1) begin n_mis++; $display("FAIL prot_flag0: got %b exp 1", prot0); end
    n_cmp++; if (prot1 !== 1'b0) begin n_mis++; $display("FAIL prot_flag1_clean: got %b exp 0", prot1); end
    @(posedge clk); #1;
    xfer(0, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, rd, err, acc, early);
    m_apply(0, 32'h20, 1'b0, 32'h0, erd, eerr);
    n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL prot_nowrite: got %h exp %h", rd, erd); end
    n_cmp++; if (acc !== 1) begin n_mis++; $display("FAIL prot_idle_after: got %0d exp 1", acc); end
    // Write on dut1 aborted by PSEL low in its second wait cycle.
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel1 = 1'b0;
    @(negedge clk);
    n_cmp++; if (pready1 !== 1'b0) begin n_mis++; $display("FAIL abort_ready: got %b exp 0", pready1); end
    @(posedge clk); #1 penable = 1'b0;
    xfer(1, 32'h08, 1'b0, 32'h0, 1'b0, 1'b0, rd, err, acc, early);
    m_apply(1, 32'h08, 1'b0, 32'h0, erd, eerr);
    n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL abort_mem: got %h exp %h", rd, erd); end
    n_cmp++; if (acc !== 4) begin n_mis++; $display("FAIL abort_idle: got %0d exp 4", acc); end
    n_cmp++; if (prot1 !== 1'b0) begin n_mis++; $display("FAIL abort_noprot: got %b exp 0", prot1); end
    // Setup repeated inside ACCESS: the second address/data win.
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h11110000;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 penable = 1'b0; paddr = 32'h34; pwdata = 32'h22220000;
    @(posedge clk); #1 penable = 1'b1;
    wait_done(1, 1'b1, rd, err, acc, early);
    psel1 = 1'b0; penable = 1'b0;
    m_apply(1, 32'h34, 1'b1, 32'h22220000, erd, eerr);
    n_cmp++; if (acc !== 4) begin n_mis++; $display("FAIL resetup_cycles: got %0d exp 4", acc); end
    n_cmp++; if (prot1 !== 1'b1) begin n_mis++; $display("FAIL resetup_prot: got %b exp 1", prot1); end
    for (int i = 0; i < 2; i++) begin
      xfer(1, 32'h30 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0, rd, err, acc, early);
      m_apply(1, 32'h30 + 32'(4 * i), 1'b0, 32'h0, erd, eerr);
      n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL resetup_mem[%0d]: got %h exp %h", i, rd, erd); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd, a; logic err, eerr; int acc; bit early;
    psel0 = 1'b1; psel1 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10; pwdata = 32'h0;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    n_cmp++; if (pready0 !== 1'b1 || prdata0 !== mem_m[0][4]) begin
      n_mis++; $display("FAIL rstmid_pre: got %b/%h exp 1/%h", pready0, prdata0, mem_m[0][4]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({pready0, pslverr0, pready1, pslverr1} !== 4'b0 || {prdata0, prdata1} !== 64'h0) begin
      n_mis++; $display("FAIL rstmid_outputs: got %b %h %h exp 0", {pready0, pslverr0, pready1, pslverr1}, prdata0, prdata1); end
    n_cmp++; if ({prot0, prot1} !== 2'b00) begin n_mis++; $display("FAIL rstmid_prot: got %b exp 00", {prot0, prot1}); end
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mem_m[d][i] = 32'h0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      a = {22'($urandom), 4'($urandom), 6'($urandom_range(0, 15) << 2)};
      xfer(k % 2, a, 1'b0, 32'h0, 1'b0, 1'b0, rd, err, acc, early);
      m_apply(k % 2, a, 1'b0, 32'h0, erd, eerr);
      n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL rstmid_clear[%0d] a=%h: got %h exp 0", k, a, rd); end
    end
    n_cmp++; if ({prot0, prot1} !== 2'b00) begin n_mis++; $display("FAIL rstmid_prot_after: got %b exp 00", {prot0, prot1}); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_random();
    test_protocol();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
